// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : uart_pkg
// Description : Shared UART types and baud-divider helpers (RX and TX).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int unsigned calc_div(input int unsigned clock_hz,
                                             input int unsigned baud_rate);
        return clock_hz / baud_rate;
    endfunction

    function automatic int unsigned calc_half(input int unsigned clock_hz,
                                              input int unsigned baud_rate);
        return calc_div(clock_hz, baud_rate) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : uart_baud
// Description : Baud tick generator; period DIV, or HALF when half is set.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_baud
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_HZ  = 10,
    parameter int unsigned BAUD_RATE = 1
) (
    input  logic resetn,
    input  logic clk,
    input  logic half,
    output logic tick
);

    localparam int unsigned DIV  = calc_div(CLOCK_HZ, BAUD_RATE);
    localparam int unsigned HALF = calc_half(CLOCK_HZ, BAUD_RATE);
    localparam int unsigned CW   = $clog2(DIV);

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    logic [CW-1:0] count;

    assign tick = (count == (half ? HALF_LAST : DIV_LAST));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : uart_rx
// Description : 8N1 UART receiver with mid-bit sampling and stop-bit check.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_HZ  = 10,
    parameter int unsigned BAUD_RATE = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error,
    output logic       busy
);

    logic        rx_meta;
    logic        rx_s;
    logic        rx_q;
    logic        start_edge;

    uart_state_t state;
    uart_state_t state_next;
    logic [2:0]  bit_count;
    logic [2:0]  bit_count_next;
    logic [7:0]  shift;
    logic [7:0]  shift_next;
    logic [7:0]  data_next;
    logic        valid_next;
    logic        frame_error_next;

    logic        tick;
    logic        half;
    logic        baud_resetn;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_q    <= rx_s;
        end
    end

    assign start_edge = rx_q & ~rx_s;

    // Holding the counter in reset on the edge cycle aligns the first tick to mid start bit.
    assign baud_resetn = resetn && !((state == IDLE) && start_edge);
    assign half        = (state == START);

    uart_baud #(
        .CLOCK_HZ  (CLOCK_HZ),
        .BAUD_RATE (BAUD_RATE)
    ) u_baud (
        .resetn (baud_resetn),
        .clk    (clk),
        .half   (half),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            bit_count   <= 3'd0;
            shift       <= 8'h00;
            data        <= 8'h00;
            valid       <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            bit_count   <= bit_count_next;
            shift       <= shift_next;
            data        <= data_next;
            valid       <= valid_next;
            frame_error <= frame_error_next;
        end
    end

    always_comb begin
        state_next       = state;
        bit_count_next   = bit_count;
        shift_next       = shift;
        data_next        = data;
        valid_next       = 1'b0;
        frame_error_next = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    bit_count_next = 3'd0;
                    state_next     = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next[bit_count] = rx_s;
                    if (bit_count == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_count_next = bit_count + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is still seen.
                if (tick) begin
                    if (rx_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
`default_nettype wire
